// File: rtl/register_file_sb_pkg.sv
// Shared types and default sizing for the register file and its consumers
// (decode and writeback).
package rf_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;
  localparam int RF_NRD    = 2;
  localparam int RF_AW     = $clog2(RF_NREGS);

  typedef logic [RF_AW-1:0]     rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_word_t;

  localparam rf_addr_t RF_ZERO = '0;
endpackage

// File: rtl/register_file_sb_if.sv
// Register file bus: read ports, writeback, reservation and debug signals.
// Decode/writeback use the master view; the register file uses the slave view.
interface register_file_sb_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int NREGS  = RF_NREGS,
  parameter int NRD    = RF_NRD
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [NRD-1:0][AW-1:0]     rsel;
  logic [NRD-1:0][DATA_W-1:0] rdat;
  logic [NRD-1:0]             rbusy;
  logic                       wen;
  logic [AW-1:0]              wsel;
  logic [DATA_W-1:0]          wdat;
  logic                       rsv_en;
  logic [AW-1:0]              rsv_sel;
  logic                       rsv_ok;
  logic                       flush;
  logic [CW-1:0]              pend_cnt;
  logic [AW-1:0]              dbg_sel;
  logic [DATA_W-1:0]          dbg_dat;

  modport master (
    output rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush, dbg_sel,
    input  rdat, rbusy, rsv_ok, pend_cnt, dbg_dat
  );

  modport slave (
    input  rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush, dbg_sel,
    output rdat, rbusy, rsv_ok, pend_cnt, dbg_dat
  );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode reservations,
// cleared by writeback, wiped by flush; also keeps a running popcount.
module rf_scoreboard #(
  parameter int   NREGS    = 32,
  parameter bit   ZERO_REG = 1'b1,
  localparam int  AW       = $clog2(NREGS),
  localparam int  CW       = $clog2(NREGS + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wen,
  input  logic [AW-1:0]    wsel,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_sel,
  input  logic             flush,
  output logic [NREGS-1:0] pending,
  output logic             rsv_ok,
  output logic [CW-1:0]    pend_cnt
);
  logic             rsv_zero;
  logic             wr_zero;
  logic             wr_hits_rsv;
  logic [NREGS-1:0] pend_nxt;
  logic [CW-1:0]    cnt_nxt;

  assign rsv_zero    = ZERO_REG && (rsv_sel == '0);
  assign wr_zero     = ZERO_REG && (wsel == '0);
  assign wr_hits_rsv = wen && (wsel == rsv_sel);

  // A pending register may only be re-reserved in the cycle its write retires.
  assign rsv_ok = rsv_en && !flush && (rsv_zero || !pending[rsv_sel] || wr_hits_rsv);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pend_nxt = pending;
    if (wen && !wr_zero) pend_nxt[wsel] = 1'b0;
    if (flush)                      pend_nxt = '0;
    else if (rsv_ok && !rsv_zero)   pend_nxt[rsv_sel] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with write-to-read bypass, a pending-write
// scoreboard for hazard detection and a registered debug read port.
module register_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = RF_NRD,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic               CLK,
  input logic               nRST,
  register_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_SEL = AW'(RF_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;
  logic              wr_act;
  logic              dbg_zero;
  logic              dbg_byp;
  logic [DATA_W-1:0] dbg_nxt;

  assign wr_act = bus.wen && !(ZERO_REG && (bus.wsel == ZERO_SEL));

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .CLK      (CLK),
    .nRST     (nRST),
    .wen      (bus.wen),
    .wsel     (bus.wsel),
    .rsv_en   (bus.rsv_en),
    .rsv_sel  (bus.rsv_sel),
    .flush    (bus.flush),
    .pending  (pending),
    .rsv_ok   (bus.rsv_ok),
    .pend_cnt (bus.pend_cnt)
  );

  // A forwarded write is by definition no longer outstanding, so bypass masks rbusy.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic zero_i;
    logic byp_i;
    assign zero_i        = ZERO_REG && (bus.rsel[i] == ZERO_SEL);
    assign byp_i         = BYPASS && bus.wen && (bus.wsel == bus.rsel[i]);
    assign bus.rdat[i]   = zero_i ? '0 : (byp_i ? bus.wdat : regs[bus.rsel[i]]);
    assign bus.rbusy[i]  = !zero_i && !byp_i && pending[bus.rsel[i]];
  end

  assign dbg_zero = ZERO_REG && (bus.dbg_sel == ZERO_SEL);
  assign dbg_byp  = BYPASS && bus.wen && (bus.wsel == bus.dbg_sel);
  assign dbg_nxt  = dbg_zero ? '0 : (dbg_byp ? bus.wdat : regs[bus.dbg_sel]);

  // NOTE: the storage array is reset because an async reset must drop any
  // in-flight architectural state, not just the control bits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_act) begin
      regs[bus.wsel] <= bus.wdat;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) bus.dbg_dat <= '0;
    else       bus.dbg_dat <= dbg_nxt;
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two configurations driven in lock-step, checked
// every cycle against an array-based model of the register file contract.
module tb_register_file_sb;
  localparam int NCFG = 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus (widest widths; narrowed per configuration)
  logic [4:0]  s_rsel    [NCFG][4];
  logic        s_wen     [NCFG];
  logic [4:0]  s_wsel    [NCFG];
  logic [63:0] s_wdat    [NCFG];
  logic        s_rsv_en  [NCFG];
  logic [4:0]  s_rsv_sel [NCFG];
  logic        s_flush   [NCFG];
  logic [4:0]  s_dbg_sel [NCFG];

  // Observed outputs (zero-extended)
  logic [63:0] o_rdat     [NCFG][4];
  logic        o_rbusy    [NCFG][4];
  logic        o_rsv_ok   [NCFG];
  logic [5:0]  o_pend_cnt [NCFG];
  logic [63:0] o_dbg      [NCFG];

  // Reference model state
  logic [63:0] m_reg  [NCFG][32];
  bit          m_pend [NCFG][32];
  logic [63:0] m_dbg  [NCFG];

  register_file_sb_if #(.DATA_W(32), .NREGS(32), .NRD(2)) bus_a ();
  register_file_sb_if #(.DATA_W(64), .NREGS(16), .NRD(3)) bus_b ();

  register_file_sb #(
    .DATA_W(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (.CLK(CLK), .nRST(nRST), .bus(bus_a));

  register_file_sb #(
    .DATA_W(64), .NREGS(16), .NRD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_b (.CLK(CLK), .nRST(nRST), .bus(bus_b));

  assign bus_a.rsel    = {s_rsel[0][1], s_rsel[0][0]};
  assign bus_a.wen     = s_wen[0];
  assign bus_a.wsel    = s_wsel[0];
  assign bus_a.wdat    = s_wdat[0][31:0];
  assign bus_a.rsv_en  = s_rsv_en[0];
  assign bus_a.rsv_sel = s_rsv_sel[0];
  assign bus_a.flush   = s_flush[0];
  assign bus_a.dbg_sel = s_dbg_sel[0];

  assign bus_b.rsel    = {s_rsel[1][2][3:0], s_rsel[1][1][3:0], s_rsel[1][0][3:0]};
  assign bus_b.wen     = s_wen[1];
  assign bus_b.wsel    = s_wsel[1][3:0];
  assign bus_b.wdat    = s_wdat[1];
  assign bus_b.rsv_en  = s_rsv_en[1];
  assign bus_b.rsv_sel = s_rsv_sel[1][3:0];
  assign bus_b.flush   = s_flush[1];
  assign bus_b.dbg_sel = s_dbg_sel[1][3:0];

  assign o_rdat[0][0]  = {32'b0, bus_a.rdat[0]};
  assign o_rdat[0][1]  = {32'b0, bus_a.rdat[1]};
  assign o_rdat[0][2]  = '0;
  assign o_rdat[0][3]  = '0;
  assign o_rbusy[0][0] = bus_a.rbusy[0];
  assign o_rbusy[0][1] = bus_a.rbusy[1];
  assign o_rbusy[0][2] = 1'b0;
  assign o_rbusy[0][3] = 1'b0;
  assign o_rsv_ok[0]   = bus_a.rsv_ok;
  assign o_pend_cnt[0] = bus_a.pend_cnt;
  assign o_dbg[0]      = {32'b0, bus_a.dbg_dat};

  assign o_rdat[1][0]  = bus_b.rdat[0];
  assign o_rdat[1][1]  = bus_b.rdat[1];
  assign o_rdat[1][2]  = bus_b.rdat[2];
  assign o_rdat[1][3]  = '0;
  assign o_rbusy[1][0] = bus_b.rbusy[0];
  assign o_rbusy[1][1] = bus_b.rbusy[1];
  assign o_rbusy[1][2] = bus_b.rbusy[2];
  assign o_rbusy[1][3] = 1'b0;
  assign o_rsv_ok[1]   = bus_b.rsv_ok;
  assign o_pend_cnt[1] = {1'b0, bus_b.pend_cnt};
  assign o_dbg[1]      = bus_b.dbg_dat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nregs(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic int nrd(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [63:0] dmask(int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // What a reader sees this cycle: r0 is zero, a matching write is forwarded.
  function automatic logic [63:0] exp_rd(int k, logic [4:0] sel);
    if (sel == 5'd0) return 64'd0;
    if (s_wen[k] && s_wsel[k] == sel) return s_wdat[k] & dmask(k);
    return m_reg[k][sel];
  endfunction

  function automatic bit exp_busy(int k, logic [4:0] sel);
    if (sel == 5'd0) return 1'b0;
    if (s_wen[k] && s_wsel[k] == sel) return 1'b0;
    return m_pend[k][sel];
  endfunction

  function automatic bit exp_rsv_ok(int k);
    if (!s_rsv_en[k] || s_flush[k]) return 1'b0;
    if (s_rsv_sel[k] == 5'd0) return 1'b1;
    return !m_pend[k][s_rsv_sel[k]] || (s_wen[k] && s_wsel[k] == s_rsv_sel[k]);
  endfunction

  function automatic int pend_count(int k);
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_pend[k][r]);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[k][r]  = 64'd0;
        m_pend[k][r] = 1'b0;
      end
      m_dbg[k] = 64'd0;
    end
  endtask

  task automatic model_edge(int k);
    bit ok;
    ok = exp_rsv_ok(k);
    m_dbg[k] = exp_rd(k, s_dbg_sel[k]);
    if (s_wen[k] && s_wsel[k] != 5'd0) begin
      m_reg[k][s_wsel[k]]  = s_wdat[k] & dmask(k);
      m_pend[k][s_wsel[k]] = 1'b0;
    end
    if (s_flush[k]) begin
      for (int r = 0; r < 32; r++) m_pend[k][r] = 1'b0;
    end else if (ok && s_rsv_sel[k] != 5'd0) begin
      m_pend[k][s_rsv_sel[k]] = 1'b1;
    end
  endtask

  task automatic idle();
    for (int k = 0; k < NCFG; k++) begin
      for (int p = 0; p < 4; p++) s_rsel[k][p] = 5'd0;
      s_wen[k]     = 1'b0;
      s_wsel[k]    = 5'd0;
      s_wdat[k]    = 64'd0;
      s_rsv_en[k]  = 1'b0;
      s_rsv_sel[k] = 5'd0;
      s_flush[k]   = 1'b0;
      s_dbg_sel[k] = 5'd0;
    end
  endtask

  task automatic set_rd(int p, int sel);
    for (int k = 0; k < NCFG; k++) s_rsel[k][p] = 5'(sel);
  endtask

  task automatic set_wr(bit en, int sel, logic [63:0] d);
    for (int k = 0; k < NCFG; k++) begin
      s_wen[k]  = en;
      s_wsel[k] = 5'(sel);
      s_wdat[k] = d;
    end
  endtask

  task automatic set_rsv(bit en, int sel, bit fl);
    for (int k = 0; k < NCFG; k++) begin
      s_rsv_en[k]  = en;
      s_rsv_sel[k] = 5'(sel);
      s_flush[k]   = fl;
    end
  endtask

  task automatic set_dbg(int sel);
    for (int k = 0; k < NCFG; k++) s_dbg_sel[k] = 5'(sel);
  endtask

  // One clock: combinational outputs checked at negedge, registered ones after posedge.
  task automatic step();
    @(negedge CLK);
    for (int k = 0; k < NCFG; k++) begin
      for (int p = 0; p < nrd(k); p++) begin
        check($sformatf("c%0d rdat%0d r%0d", k, p, s_rsel[k][p]),
              o_rdat[k][p], exp_rd(k, s_rsel[k][p]));
        check($sformatf("c%0d rbusy%0d r%0d", k, p, s_rsel[k][p]),
              64'(o_rbusy[k][p]), 64'(exp_busy(k, s_rsel[k][p])));
      end
      check($sformatf("c%0d rsv_ok r%0d", k, s_rsv_sel[k]),
            64'(o_rsv_ok[k]), 64'(exp_rsv_ok(k)));
    end
    @(posedge CLK);
    for (int k = 0; k < NCFG; k++) model_edge(k);
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("c%0d pend_cnt", k), 64'(o_pend_cnt[k]), 64'(pend_count(k)));
      check($sformatf("c%0d dbg_dat", k), o_dbg[k], m_dbg[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    model_reset();
    #3;
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("c%0d reset pend_cnt", k), 64'(o_pend_cnt[k]), 64'd0);
      check($sformatf("c%0d reset dbg_dat", k), o_dbg[k], 64'd0);
    end
    @(negedge CLK);
    nRST = 1'b1;

    // Every register on every port reads zero / not busy after reset
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < NCFG; k++) begin
        for (int p = 0; p < 4; p++) s_rsel[k][p] = 5'((r + p) % nregs(k));
        s_dbg_sel[k] = 5'(r % nregs(k));
      end
      step();
    end
    idle();

    // Same-cycle bypass, persistence, and r0 write ignored
    set_wr(1'b1, 5, 64'h0000_0000_DEAD_BEEF);
    set_rd(0, 5);
    set_dbg(5);
    #1;
    for (int k = 0; k < NCFG; k++)
      check($sformatf("c%0d bypass r5", k), o_rdat[k][0], 64'h0000_0000_DEAD_BEEF);
    step();
    set_wr(1'b0, 0, 64'd0);
    step();
    set_wr(1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    set_rd(0, 0);
    set_rd(1, 0);
    set_dbg(0);
    step();
    set_wr(1'b0, 0, 64'd0);
    step();

    // Reserve r7, refuse WAW, writeback clears
    set_rsv(1'b1, 7, 1'b0);
    set_rd(0, 7);
    step();
    for (int k = 0; k < NCFG; k++)
      check($sformatf("c%0d pend after rsv7", k), 64'(o_pend_cnt[k]), 64'd1);
    step();
    set_rsv(1'b0, 0, 1'b0);
    set_wr(1'b1, 7, 64'd3);
    #1;
    for (int k = 0; k < NCFG; k++)
      check($sformatf("c%0d rbusy7 during wb", k), 64'(o_rbusy[k][0]), 64'd0);
    step();
    set_wr(1'b0, 0, 64'd0);
    step();

    // Reserve 3,4,9 then flush alongside a reservation of r10
    set_rsv(1'b1, 3, 1'b0); step();
    set_rsv(1'b1, 4, 1'b0); step();
    set_rsv(1'b1, 9, 1'b0); set_rd(1, 9); step();
    set_rsv(1'b1, 10, 1'b1);
    #1;
    for (int k = 0; k < NCFG; k++)
      check($sformatf("c%0d rsv_ok under flush", k), 64'(o_rsv_ok[k]), 64'd0);
    step();
    set_rsv(1'b0, 0, 1'b0);
    step();

    // Write and re-reserve r12 in the same cycle
    set_rsv(1'b1, 12, 1'b0); set_rd(0, 12); step();
    set_wr(1'b1, 12, 64'h1234_5678_9ABC_DEF0);
    step();
    set_wr(1'b0, 0, 64'd0);
    set_rsv(1'b0, 0, 1'b0);
    step();
    for (int k = 0; k < NCFG; k++)
      check($sformatf("c%0d rbusy12 stays", k), 64'(o_rbusy[k][0]), 64'd1);

    // Async reset in mid-cycle drops data and reservations
    idle();
    set_wr(1'b1, 2, 64'hCAFE_F00D_5555_AAAA);
    set_dbg(2);
    step();
    set_wr(1'b0, 0, 64'd0);
    set_rsv(1'b1, 2, 1'b0);
    set_rd(0, 2);
    set_rd(1, 2);
    set_rd(2, 2);
    step();
    set_rsv(1'b0, 0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("c%0d async rdat r2", k), o_rdat[k][0], 64'd0);
      check($sformatf("c%0d async rbusy r2", k), 64'(o_rbusy[k][0]), 64'd0);
      check($sformatf("c%0d async pend_cnt", k), 64'(o_pend_cnt[k]), 64'd0);
      check($sformatf("c%0d async dbg_dat", k), o_dbg[k], 64'd0);
    end
    @(negedge CLK);
    nRST = 1'b1;
    step();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < NCFG; k++) begin
        s_wen[k]     = ($urandom_range(0, 1) == 1);
        s_wsel[k]    = 5'($urandom_range(0, nregs(k) - 1));
        s_wdat[k]    = {$urandom, $urandom};
        s_rsv_en[k]  = ($urandom_range(0, 9) < 6);
        s_rsv_sel[k] = ($urandom_range(0, 5) == 0) ? s_wsel[k]
                                                   : 5'($urandom_range(0, nregs(k) - 1));
        s_flush[k]   = ($urandom_range(0, 19) == 0);
        s_dbg_sel[k] = 5'($urandom_range(0, nregs(k) - 1));
        for (int p = 0; p < 4; p++)
          s_rsel[k][p] = ($urandom_range(0, 3) == 0) ? s_wsel[k]
                                                     : 5'($urandom_range(0, nregs(k) - 1));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
